// File: rtl/barrett_digit_serial_mult_if.sv
// rtl/barrett_digit_serial_mult_if.sv - operand inputs and datapath outputs of the Barrett digit-serial multiplier
interface barrett_digit_serial_mult_if #(
  parameter int n = 24,
  parameter int m = 4
);
  logic        [n-1:0]       X;
  logic        [m-1:0]       Y_i;
  logic        [n-1:0]       M;
  logic        [m+4:0]       mu;
  logic        [n+m+1:0]     Z_OUT;
  logic signed [n+2*m+3:0]   ADD_2;
  logic        [n+2*m+3:0]   SUB_1;
  logic signed [n+2*m+3:0]   SUB_2;
  logic        [n+2*m+1:0]   Z_IN_r;
  logic        [m+12:0]      q_mu;
  logic        [n+2*m+4:0]   Z_wire;
  logic        [m+3:0]       q_i;

  // Controller side: drives operands and digits, observes the datapath.
  modport master (
    output X, Y_i, M, mu,
    input  Z_OUT, ADD_2, SUB_1, SUB_2, Z_IN_r, q_mu, Z_wire, q_i
  );

  // Datapath side.
  modport slave (
    input  X, Y_i, M, mu,
    output Z_OUT, ADD_2, SUB_1, SUB_2, Z_IN_r, q_mu, Z_wire, q_i
  );
endinterface

// File: rtl/barrett_digit_serial_mult.sv
// rtl/barrett_digit_serial_mult.sv - radix-2^m digit-serial Barrett modular multiplier datapath (optional checks: BARRETT_ASSERT_EN)
module barrett_digit_serial_mult #(
  parameter int n = 24,
  parameter int m = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  barrett_digit_serial_mult_if.slave     bus
);
  localparam int ZW = n + m + 2;        // accumulator width
  localparam int AW = n + 2 * m + 4;    // adder/subtractor width
  localparam int QW = m + 13;           // q_mu product width

  logic [ZW-1:0]       z_q;
  logic [ZW-1:0]       z_next;
  logic [n+2*m+1:0]    z_in_r;
  logic [n+m-1:0]      xy;
  logic [AW-1:0]       add_2;
  logic [m+3:0]        z_top;
  logic [QW-1:0]       q_mu;
  logic [m+3:0]        q_i;
  logic [n+m+3:0]      qm;
  logic [AW-1:0]       sub_1;
  logic [AW-1:0]       sub_2;
  logic [AW:0]         z_wire;

  // One Barrett iteration: shift in a digit product and subtract the quotient estimate times M.
  always_comb begin
    z_in_r = {z_q, {m{1'b0}}};
    xy     = {{m{1'b0}}, bus.X} * {{n{1'b0}}, bus.Y_i};
    add_2  = {2'b00, z_in_r} + {{(m + 4){1'b0}}, xy};
    // Quotient estimate uses only the top m+4 accumulator bits and the precomputed mu.
    z_top  = z_q[ZW-1:n-2];
    q_mu   = {9'd0, z_top} * {8'd0, bus.mu};
    q_i    = q_mu[m+5 +: m+4];
    qm     = {{n{1'b0}}, q_i} * {{(m + 4){1'b0}}, bus.M};
    sub_1  = {qm, {m{1'b0}}};
    sub_2  = add_2 - sub_1;
    z_wire = {sub_2[AW-1], sub_2};
    z_next = z_wire[ZW-1:0];
  end

  // Accumulator register; reset clears it and aborts any operation in progress.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      z_q <= '0;
    end else begin
      z_q <= z_next;
    end
  end

  assign bus.Z_OUT  = z_q;
  assign bus.Z_IN_r = z_in_r;
  assign bus.ADD_2  = add_2;
  assign bus.q_mu   = q_mu;
  assign bus.q_i    = q_i;
  assign bus.SUB_1  = sub_1;
  assign bus.SUB_2  = sub_2;
  assign bus.Z_wire = z_wire;

`ifdef BARRETT_ASSERT_EN
  // Operand sanity checks on every active iteration.
  always @(posedge CLK) begin
    if (RST) begin
      if (sub_2[AW-1])
        $error("barrett: SUB_2 negative X=%0d Y_i=%0d M=%0d mu=%0d Z_OUT=%0d", bus.X, bus.Y_i, bus.M, bus.mu, z_q);
      else if (sub_2[AW-2:ZW] != '0)
        $error("barrett: accumulator overflow X=%0d Y_i=%0d M=%0d mu=%0d Z_OUT=%0d", bus.X, bus.Y_i, bus.M, bus.mu, z_q);
      if (!bus.M[n-1])
        $error("barrett: modulus MSB clear X=%0d Y_i=%0d M=%0d mu=%0d Z_OUT=%0d", bus.X, bus.Y_i, bus.M, bus.mu, z_q);
    end
  end
`else
  // Checks compiled out; datapath is unchanged.
`endif

endmodule

// File: tb/tb_barrett_digit_serial_mult.sv
// tb/tb_barrett_digit_serial_mult.sv - randomized and directed bench for barrett_digit_serial_mult
module tb_barrett_digit_serial_mult;
  localparam int N  = 24;
  localparam int MD = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   tests = 0;
  int   fails = 0;

  longint cur_x, cur_m, cur_mu, exp_z;

  barrett_digit_serial_mult_if #(.n(N), .m(MD)) bus ();

  barrett_digit_serial_mult #(.n(N), .m(MD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Quotient estimate and iteration written directly from the arithmetic definition.
  function automatic longint model_q(input longint z, input longint muv);
    return ((z >> (N - 2)) * muv) >> (MD + 5);
  endfunction

  function automatic longint model_next(input longint z, input longint x, input longint y,
                                        input longint mm, input longint muv);
    return z * (64'd1 << MD) + x * y - model_q(z, muv) * mm * (64'd1 << MD);
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_ops(input longint x, input longint mm, input longint muv);
    cur_x  = x;
    cur_m  = mm;
    cur_mu = muv;
    bus.X  = x[N-1:0];
    bus.M  = mm[N-1:0];
    bus.mu = muv[MD+4:0];
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    bus.Y_i = '0;
    @(posedge CLK);
    #1;
    exp_z = 0;
    check("reset_z_out", longint'(bus.Z_OUT), 0);
  endtask

  task automatic iter(input logic [MD-1:0] y);
    @(negedge CLK);
    RST = 1'b1;
    bus.Y_i = y;
    exp_z = model_next(exp_z, cur_x, longint'(y), cur_m, cur_mu);
    @(posedge CLK);
    #1;
    check("iter_z_out", longint'(bus.Z_OUT), exp_z);
    check("iter_q_i", longint'(bus.q_i), model_q(exp_z, cur_mu));
  endtask

  task automatic run_op(input longint a, input longint b, input longint mm, input longint muv,
                        input bit zero_track, output longint raw, output longint res);
    logic [N-1:0] bv;
    bv = b[N-1:0];
    @(negedge CLK);
    set_ops(a, mm, muv);
    do_reset();
    for (int k = N / MD; k >= 1; k--) begin
      iter(bv[(k-1)*MD +: MD]);
      if (zero_track) check("zero_z_out", longint'(bus.Z_OUT), 0);
    end
    iter('0);
    raw = longint'(bus.Z_OUT);
    res = raw >> MD;
    if (res >= mm) res = res - mm;
  endtask

  initial begin
    longint raw, res, a, b, mm, muv;
    bus.X = '0; bus.Y_i = '0; bus.M = '0; bus.mu = '0;
    cur_x = 0; cur_m = 0; cur_mu = 0; exp_z = 0;

    // Reset from a non-zero accumulator.
    set_ops(5, 16777213, 128);
    do_reset();
    iter(4'd9);
    iter(4'd7);
    iter(4'hf);
    do_reset();
    check("reset_q_i", longint'(bus.q_i), 0);
    check("reset_sub_1", longint'(bus.SUB_1), 0);

    // Single iteration: 5*3 into an empty accumulator.
    iter(4'd3);
    check("single_z_out", longint'(bus.Z_OUT), 15);
    check("single_z_in_r", longint'(bus.Z_IN_r), 240);
    check("single_add_2", longint'(bus.ADD_2), 255);

    // Directed full operations.
    run_op(16777212, 16777212, 16777213, 128, 1'b0, raw, res);
    check("full_max", res, 1);
    run_op(8388608, 2, 8388609, 255, 1'b0, raw, res);
    check("full_half", res, 8388607);
    run_op(0, 24'hABCDEF, 16777213, 128, 1'b1, raw, res);
    check("zero_result", res, 0);

    // Reset in the middle of an operation, then restart.
    @(negedge CLK);
    set_ops(16777212, 16777213, 128);
    do_reset();
    iter(4'hf);
    iter(4'hf);
    @(negedge CLK);
    RST = 1'b0;
    bus.Y_i = 4'hf;
    @(posedge CLK);
    #1;
    check("midop_reset_z_out", longint'(bus.Z_OUT), 0);
    run_op(16777212, 16777212, 16777213, 128, 1'b0, raw, res);
    check("midop_restart", res, 1);

    // Random moduli and operands: result must be congruent to A*B mod M.
    for (int t = 0; t < 20; t++) begin
      mm  = longint'($urandom_range(32'hFFFFFF, 32'h800000));
      muv = (64'd1 << (N + MD + 3)) / mm;
      a   = longint'($urandom) % mm;
      b   = longint'($urandom) % mm;
      run_op(a, b, mm, muv, 1'b0, raw, res);
      check("rand_congruence", (raw >> MD) % mm, (a * b) % mm);
      check("rand_low_digit", raw % (64'd1 << MD), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/barrett_digit_serial_mult.md
# barrett_digit_serial_mult

Radix-2^m digit-serial Barrett modular multiplier datapath. It accumulates X·Y one m-bit digit of Y per clock, MSB digit first, and performs an approximate Barrett reduction each cycle using a precomputed constant mu. It sits inside a modular-multiplication unit. The surrounding controller sequences the digits, extracts the result, and applies the final conditional subtraction.

## Interface
Parameters:
- n, 24, operand/modulus width; must be a multiple of m
- m, 4, digit width; m ≤ 4, so the q_mu product fits in m+13 bits

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; synchronous, active-low; clears the accumulator
- X  in  n  multiplicand, held stable for the whole operation
- Y_i  in  m  current digit of the multiplier
- M  in  n  modulus; M[n-1] must be 1
- mu  in  m+5  Barrett constant, floor(2^(n+m+3)/M)
- Z_OUT  out  n+m+2  accumulator register
- ADD_2  out  n+2m+4 signed  Z_IN_r + X·Y_i
- SUB_1  out  n+2m+4  q_i·M·2^m
- SUB_2  out  n+2m+4 signed  ADD_2 − SUB_1
- Z_IN_r  out  n+2m+2  Z_OUT·2^m
- q_mu  out  m+13  (Z_OUT>>(n−2))·mu
- Z_wire  out  n+2m+5  SUB_2 sign-extended
- q_i  out  m+4  q_mu>>(m+5)

## Operation
- All debug outputs are combinational functions of Z_OUT, X, Y_i, M and mu, computed with unsigned full-precision arithmetic, then zero-extended or sign-extended to the port width.
- Next accumulator value: Z_OUT ← Z_wire[n+m+1:0].
- For valid inputs SUB_2 is never negative and fits in n+m+2 bits.
- Sequence for A·B mod M:
  - Reset the block.
  - Apply X=A.
  - Apply the digits Y_i = B[(k−1)m +: m] for k = n/m down to 1, one per cycle.
  - Apply one extra cycle with Y_i=0.
- Result extraction, outside this block:
  - Z = Z_OUT>>m.
  - If Z ≥ M, then Z ← Z − M.
  - Z then equals (A·B) mod M.
- The block holds no control state and no digit counter; the caller does all sequencing.

## Timing
- Reset: when RST=0 at a rising edge, Z_OUT ← 0. Reset overrides the update. The debug outputs then follow combinationally.
- Each rising edge with RST=1 performs exactly one iteration using the Y_i present at that edge.
- Y_i, X, M and mu must be stable around the edge; the bench drives them on the falling edge.
- Latency: n/m+1 iterations after reset release. With the default parameters this is 7 cycles. The result is valid on Z_OUT after the 7th edge.
- Reset mid-operation: Z_OUT is 0 after that edge. The operation is aborted and must be restarted from the MSB digit.
- No handshake signals; the block is always ready.

## Configuration
- BARRETT_ASSERT_EN defined: simulation-only checks on every rising edge with RST=1. Each check prints an $error with the current operand values:
  - SUB_2 < 0
  - SUB_2 ≥ 2^(n+m+2), i.e. accumulator overflow
  - M[n-1] = 0
- BARRETT_ASSERT_EN undefined: no checks; the logic and ports are identical.

## Test plan
Defaults n=24, m=4.
- Reset: RST=0 for one edge with arbitrary Z_OUT → Z_OUT=0, q_i=0, SUB_1=0.
- Single iteration after reset: X=5, Y_i=3, M=16777213, mu=128 → one edge → Z_OUT=15.
- Full operation: A=B=16777212, M=16777213, mu=128, 7 iterations → Z_OUT>>4 after correction = 1.
- Full operation: A=8388608, B=2, M=8388609, mu=255 → corrected result = 8388607.
- Zero operand: A=0, B=0xABCDEF, M=16777213, mu=128 → Z_OUT stays 0 every cycle; result 0.
- Reset mid-operation: assert RST=0 at the 3rd digit → Z_OUT=0 next edge. Restart with A=B=16777212 → result 1. With BARRETT_ASSERT_EN defined, no assertion fires.
